// File: rtl/tt_vector_player_if.sv
// rtl/tt_vector_player_if.sv - table-load, run-control, status and project io bundle for the vector player
interface tt_vector_player_if #(
    parameter int ADDR_W = 4,
    parameter int ERR_W  = 8
);
    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_stim;
    logic [7:0]        ld_exp;
    logic [7:0]        ld_mask;
    logic              start;
    logic [ADDR_W:0]   num_vec;
    logic [7:0]        dut_io_in;
    logic [7:0]        dut_io_out;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic              err_valid;
    logic [ADDR_W-1:0] first_err_idx;
    logic [7:0]        first_err_obs;

    modport master (
        output ld_en, ld_addr, ld_stim, ld_exp, ld_mask, start, num_vec, dut_io_out,
        input  dut_io_in, busy, done, pass, err_count, err_valid, first_err_idx, first_err_obs
    );

    modport slave (
        input  ld_en, ld_addr, ld_stim, ld_exp, ld_mask, start, num_vec, dut_io_out,
        output dut_io_in, busy, done, pass, err_count, err_valid, first_err_idx, first_err_obs
    );
endinterface

// File: rtl/tt_vector_player.sv
// rtl/tt_vector_player.sv - drives stored stimulus onto a TinyTapeout io_in and checks io_out under mask
module tt_vector_player #(
    parameter int ADDR_W = 4,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    tt_vector_player_if.slave    bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_V = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [7:0]        r_stim [DEPTH];
    logic [7:0]        r_exp  [DEPTH];
    logic [7:0]        r_mask [DEPTH];

    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W:0]   r_n;
    logic [7:0]        r_cnt;
    logic [7:0]        r_dut_in;
    logic [ERR_W-1:0]  r_err_count;
    logic              r_err_valid;
    logic [ADDR_W-1:0] r_first_idx;
    logic [7:0]        r_first_obs;

    logic              w_busy;
    logic              w_accept;
    logic              w_mismatch;
    logic              w_last;
    logic [ADDR_W:0]   w_n;

    assign w_busy     = (r_state == S_DRIVE) || (r_state == S_SETTLE) || (r_state == S_CHECK);
    assign w_accept   = ((r_state == S_IDLE) || (r_state == S_DONE)) && bus.start && (bus.num_vec != '0);
    assign w_n        = (bus.num_vec > DEPTH_V) ? DEPTH_V : bus.num_vec;
    assign w_mismatch = |((bus.dut_io_out ^ r_exp[r_idx]) & r_mask[r_idx]);
    assign w_last     = ({1'b0, r_idx} == (r_n - 1'b1));

    // Table is deliberately outside reset so a reset does not lose loaded vectors.
    always_ff @(posedge i_clk) begin
        if (bus.ld_en && !w_busy) begin
            r_stim[bus.ld_addr] <= bus.ld_stim;
            r_exp[bus.ld_addr]  <= bus.ld_exp;
            r_mask[bus.ld_addr] <= bus.ld_mask;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_DRIVE;
            S_DRIVE:  w_next = S_SETTLE;
            S_SETTLE: if (r_cnt == 8'd0) w_next = S_CHECK;
            S_CHECK:  w_next = w_last ? S_DONE : S_DRIVE;
            S_DONE:   if (w_accept) w_next = S_DRIVE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx       <= '0;
            r_n         <= '0;
            r_cnt       <= '0;
            r_dut_in    <= '0;
            r_err_count <= '0;
            r_err_valid <= 1'b0;
            r_first_idx <= '0;
            r_first_obs <= '0;
        end else begin
            if (w_accept) begin
                r_n         <= w_n;
                r_idx       <= '0;
                r_err_count <= '0;
                r_err_valid <= 1'b0;
                r_first_idx <= '0;
                r_first_obs <= '0;
            end
            case (r_state)
                S_DRIVE: begin
                    r_dut_in <= r_stim[r_idx];
                    r_cnt    <= 8'(SETTLE - 1);
                end
                S_SETTLE: begin
                    if (r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_count != {ERR_W{1'b1}}) r_err_count <= r_err_count + 1'b1;
                        if (!r_err_valid) begin
                            r_err_valid <= 1'b1;
                            r_first_idx <= r_idx;
                            r_first_obs <= bus.dut_io_out;
                        end
                    end
                    if (!w_last) r_idx <= r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.dut_io_in     = r_dut_in;
    assign bus.busy          = w_busy;
    assign bus.done          = (r_state == S_DONE);
    assign bus.pass          = (r_state == S_DONE) && (r_err_count == '0);
    assign bus.err_count     = r_err_count;
    assign bus.err_valid     = r_err_valid;
    assign bus.first_err_idx = r_first_idx;
    assign bus.first_err_obs = r_first_obs;
endmodule

// File: tb/tb_tt_vector_player.sv
// tb/tb_tt_vector_player.sv - directed vector bench for tt_vector_player (loopback project model)
module tb_tt_vector_player;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    tt_vector_player_if #(.ADDR_W(4), .ERR_W(8)) bus ();
    tt_vector_player_if #(.ADDR_W(4), .ERR_W(2)) bus2 ();

    assign bus.dut_io_out  = bus.dut_io_in;
    assign bus2.dut_io_out = bus2.dut_io_in;

    tt_vector_player #(.ADDR_W(4), .SETTLE(2), .ERR_W(8)) u_dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus.slave)
    );

    tt_vector_player #(.ADDR_W(4), .SETTLE(2), .ERR_W(2)) u_dut2 (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus2.slave)
    );

    typedef struct {
        logic [4:0] num;
        logic [7:0] exp3;
        logic [7:0] mask3;
        int         cycles;
        int         err;
        logic       pass;
        logic       valid;
        int         fidx;
        int         fobs;
    } rec_t;

    rec_t recs [6];

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic load(input int addr, input int stim, input int exp, input int mask);
        @(negedge clk);
        bus.ld_en   = 1'b1;
        bus.ld_addr = 4'(addr);
        bus.ld_stim = 8'(stim);
        bus.ld_exp  = 8'(exp);
        bus.ld_mask = 8'(mask);
        @(posedge clk);
        #1 bus.ld_en = 1'b0;
    endtask

    task automatic run(input int num, output int cyc);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.num_vec = 5'(num);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " dut_io_in"}, int'(bus.dut_io_in), 0);
        check({tag, " busy"}, int'(bus.busy), 0);
        check({tag, " done"}, int'(bus.done), 0);
        check({tag, " pass"}, int'(bus.pass), 0);
        check({tag, " err_count"}, int'(bus.err_count), 0);
        check({tag, " err_valid"}, int'(bus.err_valid), 0);
        check({tag, " first_err_idx"}, int'(bus.first_err_idx), 0);
        check({tag, " first_err_obs"}, int'(bus.first_err_obs), 0);
    endtask

    initial begin
        int cyc;
        int w;

        recs[0] = '{num: 5'd8, exp3: 8'h03, mask3: 8'hFF, cycles: 32, err: 0, pass: 1'b1, valid: 1'b0, fidx: 0, fobs: 8'h00};
        recs[1] = '{num: 5'd8, exp3: 8'h13, mask3: 8'hFF, cycles: 32, err: 1, pass: 1'b0, valid: 1'b1, fidx: 3, fobs: 8'h03};
        recs[2] = '{num: 5'd8, exp3: 8'h13, mask3: 8'h0F, cycles: 32, err: 0, pass: 1'b1, valid: 1'b0, fidx: 0, fobs: 8'h00};
        recs[3] = '{num: 5'd8, exp3: 8'hAA, mask3: 8'h00, cycles: 32, err: 0, pass: 1'b1, valid: 1'b0, fidx: 0, fobs: 8'h00};
        recs[4] = '{num: 5'd3, exp3: 8'h13, mask3: 8'hFF, cycles: 12, err: 0, pass: 1'b1, valid: 1'b0, fidx: 0, fobs: 8'h00};
        recs[5] = '{num: 5'd4, exp3: 8'hAA, mask3: 8'h80, cycles: 16, err: 1, pass: 1'b0, valid: 1'b1, fidx: 3, fobs: 8'h03};

        bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_stim = '0; bus.ld_exp = '0; bus.ld_mask = '0;
        bus.start = 1'b0; bus.num_vec = '0;
        bus2.ld_en = 1'b0; bus2.ld_addr = '0; bus2.ld_stim = '0; bus2.ld_exp = '0; bus2.ld_mask = '0;
        bus2.start = 1'b0; bus2.num_vec = '0;

        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        @(negedge clk) reset = 1'b0;

        // Reset while a vector is settling.
        for (int i = 0; i < 8; i++) load(i, i, i, 8'hFF);
        load(0, 8'h5A, 8'h5A, 8'hFF);
        @(negedge clk);
        bus.start = 1'b1; bus.num_vec = 5'd8;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 check("settle dut_io_in", int'(bus.dut_io_in), 8'h5A);
        reset = 1'b1;
        @(posedge clk);
        #1 check_zero("midrun reset");
        reset = 1'b0;
        load(0, 0, 0, 8'hFF);

        foreach (recs[r]) begin
            for (int i = 0; i < 8; i++) begin
                if (i == 3) load(i, i, recs[r].exp3, recs[r].mask3);
                else        load(i, i, i, 8'hFF);
            end
            run(recs[r].num, cyc);
            check($sformatf("rec%0d cycles", r), cyc, recs[r].cycles);
            check($sformatf("rec%0d err_count", r), int'(bus.err_count), recs[r].err);
            check($sformatf("rec%0d pass", r), int'(bus.pass), int'(recs[r].pass));
            check($sformatf("rec%0d err_valid", r), int'(bus.err_valid), int'(recs[r].valid));
            check($sformatf("rec%0d first_err_idx", r), int'(bus.first_err_idx), recs[r].fidx);
            check($sformatf("rec%0d first_err_obs", r), int'(bus.first_err_obs), recs[r].fobs);
            check($sformatf("rec%0d last stim", r), int'(bus.dut_io_in), int'(recs[r].num) - 1);
        end

        // num_vec=0 leaves the finished run untouched.
        @(negedge clk);
        bus.start = 1'b1; bus.num_vec = 5'd0;
        repeat (3) @(posedge clk);
        #1 check("numvec0 busy", int'(bus.busy), 0);
        check("numvec0 done", int'(bus.done), 1);
        bus.start = 1'b0;

        // Saturating error counter: every expected value wrong.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus2.ld_en = 1'b1; bus2.ld_addr = 4'(i); bus2.ld_stim = 8'(i);
            bus2.ld_exp = 8'(i) ^ 8'hFF; bus2.ld_mask = 8'hFF;
        end
        @(negedge clk);
        bus2.ld_en = 1'b0;
        bus2.start = 1'b1; bus2.num_vec = 5'd8;
        @(negedge clk);
        bus2.start = 1'b0;
        w = 0;
        while (!bus2.done && w < 2000) begin
            @(posedge clk);
            #1 w++;
        end
        check("sat done", int'(bus2.done), 1);
        check("sat err_count", int'(bus2.err_count), 3);
        check("sat first_err_idx", int'(bus2.first_err_idx), 0);
        check("sat first_err_obs", int'(bus2.first_err_obs), 0);
        check("sat pass", int'(bus2.pass), 0);

        // Writes and starts while busy are dropped.
        for (int i = 0; i < 8; i++) load(i, i, i, 8'hFF);
        @(negedge clk);
        bus.start = 1'b1; bus.num_vec = 5'd8;
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
            if (cyc == 8) begin
                bus.ld_en = 1'b1; bus.ld_addr = 4'd5; bus.ld_stim = 8'hFF;
                bus.ld_exp = 8'hEE; bus.ld_mask = 8'hFF;
                bus.start = 1'b1; bus.num_vec = 5'd1;
            end
            if (cyc == 14) begin
                bus.ld_en = 1'b0; bus.start = 1'b0;
            end
        end
        check("busy-ignore cycles", cyc, 32);
        check("busy-ignore err_count", int'(bus.err_count), 0);
        check("busy-ignore pass", int'(bus.pass), 1);
        check("busy-ignore last stim", int'(bus.dut_io_in), 7);

        // num_vec above DEPTH clamps to 16; upper half deliberately wrong.
        for (int i = 8; i < 16; i++) load(i, i, i ^ 1, 8'hFF);
        run(20, cyc);
        check("clamp cycles", cyc, 64);
        check("clamp err_count", int'(bus.err_count), 8);
        check("clamp first_err_idx", int'(bus.first_err_idx), 8);
        check("clamp first_err_obs", int'(bus.first_err_obs), 8'h08);
        check("clamp last stim", int'(bus.dut_io_in), 8'h0F);

        // Write and accepted start on the same edge: the run sees the new entry.
        @(negedge clk);
        bus.ld_en = 1'b1; bus.ld_addr = 4'd0; bus.ld_stim = 8'h00;
        bus.ld_exp = 8'h55; bus.ld_mask = 8'hFF;
        bus.start = 1'b1; bus.num_vec = 5'd1;
        @(posedge clk);
        #1 bus.ld_en = 1'b0; bus.start = 1'b0;
        cyc = 0;
        while (!bus.done && cyc < 2000) begin
            @(posedge clk);
            #1 cyc++;
        end
        check("same-edge cycles", cyc, 4);
        check("same-edge err_count", int'(bus.err_count), 1);
        check("same-edge first_err_obs", int'(bus.first_err_obs), 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
